// File: rtl/iob_fifo_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iob_fifo_sp_ctrl
// Purpose  : Controller for a FIFO built on an external single-port register
//            file, with a registered output stage. The regfile can do only
//            one access per cycle, so reads and writes share it. When both
//            are wanted, they alternate cycle by cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        rising-edge clock
//   arst_n_i     asynchronous active-low reset
//   clr_i        synchronous soft clear (active-high)
//   in_valid_i   push request
//   in_data_i    push data
//   in_ready_o   push accepted when high together with in_valid_i
//   out_valid_o  output register holds a valid head word
//   out_data_o   registered head word
//   out_ready_i  consumer takes the head word
//   level_o      words held in the regfile (output register excluded)
//   rf_we_o      regfile write enable
//   rf_addr_o    regfile shared read/write address
//   rf_w_data_o  regfile write data
//   rf_r_data_i  regfile combinational read data at rf_addr_o
// ============================================================================
module iob_fifo_sp_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [ADDR_W:0]   level_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_w_data_o,
  input  logic [DATA_W-1:0] rf_r_data_i
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  // Last regfile access; used to alternate reads and writes when both are wanted.
  typedef enum logic [0:0] {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  op_e               last_op_q,   last_op_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W:0]   level_q,     level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic full;
  logic read_need;
  logic rd_gnt;
  logic in_ready;
  logic push;

  always_comb begin
    full      = (level_q == LEVEL_FULL);
    // The output register is empty now, or it is being emptied this cycle.
    read_need = (level_q != '0) && (!out_valid_q || out_ready_i);
    // A read wins if the last access was a write, if there is no competing
    // push, or if the regfile is full. Clear suppresses every access.
    rd_gnt    = !clr_i && read_need &&
                ((last_op_q == OP_WRITE) || !in_valid_i || full);
    in_ready  = !full && !rd_gnt && !clr_i;
    push      = in_valid_i && in_ready;
  end

  // Regfile port: the address defaults to wr_ptr when the regfile is idle.
  assign rf_we_o     = push;
  assign rf_addr_o   = rd_gnt ? rd_ptr_q : wr_ptr_q;
  assign rf_w_data_o = in_data_i;

  always_comb begin
    last_op_d   = last_op_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (clr_i) begin
      last_op_d   = OP_READ;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        level_d   = level_q + 1'b1;
        last_op_d = OP_WRITE;
      end
      if (rd_gnt) begin
        // A read refills the output register, even if the consumer takes
        // the current word in the same cycle.
        rd_ptr_d    = rd_ptr_q + 1'b1;
        level_d     = level_q - 1'b1;
        last_op_d   = OP_READ;
        out_data_d  = rf_r_data_i;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_op_q   <= OP_READ;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      last_op_q   <= last_op_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign level_o     = level_q;

endmodule
`default_nettype wire

// File: doc/iob_fifo_sp_ctrl.md
IOB_FIFO_SP_CTRL -- requirements
Module: iob_fifo_sp_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, regfile address width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter DATA_W, default 21, data word width.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port arst_n_i, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port clr_i, input, 1: synchronous soft clear, active-high.
REQ-006 SHALL have port in_valid_i, input, 1: push request.
REQ-007 SHALL have port in_data_i, input, DATA_W: push data.
REQ-008 SHALL have port in_ready_o, output, 1: push accepted this cycle when high with in_valid_i.
REQ-009 SHALL have port out_valid_o, output, 1: output register holds valid head word.
REQ-010 SHALL have port out_data_o, output, DATA_W: head word (registered).
REQ-011 SHALL have port out_ready_i, input, 1: consumer takes head word.
REQ-012 SHALL have port level_o, output, ADDR_W+1: words held in regfile, excluding output register.
REQ-013 SHALL have port rf_we_o, output, 1: write enable to single-port regfile.
REQ-014 SHALL have port rf_addr_o, output, ADDR_W: shared read/write address to regfile.
REQ-015 SHALL have port rf_w_data_o, output, DATA_W: write data to regfile.
REQ-016 SHALL have port rf_r_data_i, input, DATA_W: combinational read data from regfile at rf_addr_o.

Function
REQ-017 SHALL perform at most one regfile access per cycle: either one write or one read, never both.
REQ-018 SHALL compute read_need = (level != 0) && (!out_valid_o || out_ready_i).
REQ-019 SHALL grant a read (rd_gnt) when read_need && (last_op_q == WRITE || !in_valid_i || level == DEPTH).
REQ-020 SHALL drive in_ready_o = (level < DEPTH) && !rd_gnt && !clr_i; out_valid_o SHALL NOT depend on out_ready_i or in_valid_i.
REQ-021 SHALL, on push handshake, assert rf_we_o, drive rf_addr_o = wr_ptr, rf_w_data_o = in_data_i, advance wr_ptr mod DEPTH, set last_op_q = WRITE.
REQ-022 SHALL, on rd_gnt, drive rf_addr_o = rd_ptr, rf_we_o = 0, load rf_r_data_i into out_data_o at the edge, set out_valid_o = 1, advance rd_ptr mod DEPTH, set last_op_q = READ.
REQ-023 SHALL, when neither access occurs, drive rf_we_o = 0, rf_addr_o = wr_ptr; last_op_q unchanged.
REQ-024 SHALL clear out_valid_o when out_valid_o && out_ready_i and no rd_gnt that cycle; pop with rd_gnt in same cycle keeps out_valid_o = 1 with new data.
REQ-025 SHALL update level: +1 on push only, -1 on rd_gnt only; no change otherwise (push and rd_gnt exclusive).
REQ-026 Latency: word pushed at edge k into empty FIFO with out_valid_o = 0 SHALL appear on out_data_o with out_valid_o = 1 after edge k+1.
REQ-027 Full (level == DEPTH): in_ready_o = 0; reads granted regardless of priority.
REQ-028 Empty (level == 0): no read; in_ready_o = 1 if !clr_i.
REQ-029 Contention (read_need && in_valid_i): SHALL alternate read/write cycle by cycle via last_op_q; sustained throughput 1 word per 2 cycles each way.
REQ-030 Pointer wrap: wr_ptr and rd_ptr SHALL wrap DEPTH-1 -> 0 without loss.
REQ-031 clr_i SHALL, at the edge, zero wr_ptr, rd_ptr, level, out_valid_o, set last_op_q = READ; rf_we_o = 0 and in_ready_o = 0 while clr_i high; clr_i overrides simultaneous push/pop.

Reset
REQ-032 On arst_n_i low, immediately: wr_ptr = 0, rd_ptr = 0, level_o = 0, out_valid_o = 0, out_data_o = 0, last_op_q = READ; regfile contents not cleared (unread).
REQ-033 Reset SHALL release synchronously to clk_i; first push accepted on first edge after release; reset mid-transfer discards all held words.

Verification (DEPTH = 4, DATA_W = 21)
REQ-034 Push 0x00001 into empty, out_ready_i = 0 -> rf_we_o = 1 addr 0 at edge k; out_valid_o = 1, out_data_o = 0x00001, level_o = 0 after edge k+1.
REQ-035 out_ready_i = 0, push 0x10..0x14 back-to-back -> first to output reg, next 4 fill regfile; level_o = 4, in_ready_o = 0; 6th push stalls.
REQ-036 Continuous in_valid_i and out_ready_i with level_o = 2 -> rf_we_o alternates 1/0 each cycle, output order equals input order, no duplicates.
REQ-037 Push/pop 10 words through DEPTH 4 -> wr_ptr and rd_ptr wrap twice; data sequence 0..9 preserved.
REQ-038 clr_i pulse with level_o = 3, out_valid_o = 1, in_valid_i = 1 -> level_o = 0, out_valid_o = 0, rf_we_o = 0 that cycle; next push lands at addr 0.
REQ-039 arst_n_i low mid-stream asynchronously -> out_valid_o = 0, level_o = 0 before next edge; after release, push 0x0ABCD emerges after 2 edges.
